// File: rtl/rmw_mem_engine.sv
// Serialised read / write / read-modify-write engine over a single-port word memory.
// Plain writes are scrambled with XOR_KEY; reads return raw stored words.
module rmw_mem_engine #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] XOR_KEY = DATA_W'(32'hDEADBEEF),
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_old;
    logic [DATA_W-1:0]   r_new;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_busy;
    logic [CNT_W-1:0]    r_op_count;

    logic [DATA_W-1:0]   r_mem [1<<ADDR_W];

    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_wr_word;

    assign w_rd_word = r_mem[r_addr];
    assign w_wr_word = (r_op == OP_WR) ? (r_data ^ XOR_KEY) : r_new;

    // No reset on the array; gating on r_state means an async reset before the
    // WRITE edge suppresses the store.
    always_ff @(posedge clk) begin
        if (r_state == S_WRITE)
            r_mem[r_addr] <= w_wr_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_old       <= '0;
            r_new       <= '0;
            r_rsp_data  <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_data      <= req_data;
                        r_state     <= (req_op == OP_WR) ? S_WRITE : S_READ;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_READ: begin
                    r_old <= w_rd_word;
                    if (r_op == OP_RD) begin
                        r_rsp_data  <= w_rd_word;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_MODIFY;
                    end
                end
                S_MODIFY: begin
                    r_new   <= (r_op == OP_XOR) ? (r_old ^ r_data) : (r_old + r_data);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    // Plain writes echo the scrambled word; RMWs return the pre-modify value.
                    r_rsp_data  <= (r_op == OP_WR) ? w_wr_word : r_old;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: doc/rmw_mem_engine.md
RMW_MEM_ENGINE -- requirements
Module: rmw_mem_engine

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, address width; memory depth = 2^ADDR_W words.
REQ-002 SHALL provide parameter DATA_W, default 32, word width.
REQ-003 SHALL provide parameter XOR_KEY, default 32'hDEADBEEF (DATA_W bits), scramble key applied to plain writes.
REQ-004 SHALL provide parameter CNT_W, default 8, completed-operation counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports:
  clk        in   1       clock, rising edge
  reset      in   1       asynchronous active-low reset
  req_valid  in   1       request present
  req_ready  out  1       engine accepts request
  req_op     in   2       00 read, 01 write, 10 xor-RMW, 11 add-RMW
  req_addr   in   ADDR_W  word address
  req_data   in   DATA_W  write/operand data
  rsp_valid  out  1       response present
  rsp_ready  in   1       consumer accepts response
  rsp_data   out  DATA_W  response word
  busy       out  1       high whenever state != IDLE
  op_count   out  CNT_W   completed responses, modulo 2^CNT_W

Function
REQ-007 SHALL implement FSM states IDLE, READ, MODIFY, WRITE, RESP; req_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-008 SHALL accept a request only on an edge with req_valid && req_ready, capturing op, addr, and data into internal registers; the bench may change inputs afterwards.
REQ-009 On accept: op 00 -> READ; op 01 -> WRITE; op 10/11 -> READ.
REQ-010 READ SHALL latch mem[addr] into the old-value register on the next edge; op 00 -> RESP; op 10/11 -> MODIFY.
REQ-011 MODIFY SHALL compute new = old ^ data (op 10) or new = (old + data) mod 2^DATA_W (op 11, carry discarded) on the next edge -> WRITE.
REQ-012 WRITE SHALL store exactly one word on the next edge -> RESP. The stored word is data ^ XOR_KEY for op 01, or new for op 10/11.
REQ-013 rsp_data SHALL be:
  - the old value for op 00/10/11;
  - the stored (scrambled) word for op 01.
REQ-014 Latency from the accept edge to rsp_valid high SHALL be 2 edges for op 00/01 and 4 edges for op 10/11.
REQ-015 RESP SHALL hold rsp_valid and a stable rsp_data until an edge with rsp_ready=1. That edge -> IDLE and op_count += 1, wrapping from 2^CNT_W-1 to 0.
REQ-016 req_valid while not IDLE SHALL be ignored (no capture, no side effect); the requester must hold the request.
REQ-017 If rsp_ready is already high on the edge entering RESP, rsp_valid SHALL still be high for at least one cycle.
REQ-018 Reads SHALL return raw stored words; no descrambling.
REQ-019 An RMW to the same address as the previous operation SHALL observe that operation's written value; there is no bypass hazard because operations are serialised.
REQ-020 Memory SHALL be single-port, written only in WRITE, and read only in READ.

Reset
REQ-021 reset low SHALL immediately force state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, busy=0, op_count=0, and clear the internal registers.
REQ-022 Memory contents SHALL NOT be cleared by reset and are undefined after power-up.
REQ-023 Reset mid-operation SHALL abort it:
  - no write if reset is asserted before the WRITE edge;
  - no response is issued;
  - op_count is not incremented.
REQ-024 The first request SHALL be accepted on the first rising edge after reset deassertion with req_valid=1.

Verification
REQ-025 Write/read: op01 addr 5 data 0 -> rsp_data 32'hDEADBEEF after 2 edges; then op00 addr 5 -> rsp_data 32'hDEADBEEF; op_count=2.
REQ-026 Add wrap: mem[5]=32'hDEADBEEF; op11 addr 5 data 32'h21524111 -> rsp_data 32'hDEADBEEF after 4 edges; then op00 addr 5 -> 32'h00000000.
REQ-027 XOR: mem[7]=32'hDEADBEEF via op01 data 0; op10 addr 7 data 32'hFFFFFFFF -> rsp 32'hDEADBEEF; then read addr 7 -> 32'h21524110.
REQ-028 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid held, rsp_data stable, req_ready=0, and a new req_valid is ignored; release -> IDLE next edge.
REQ-029 Reset abort: assert reset in MODIFY of op11 addr 9 -> outputs at reset values, mem[9] unchanged, op_count unchanged.
REQ-030 Counter wrap: 256 read handshakes with CNT_W=8 -> op_count returns to 0.
